// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predict unit: RISC-V control opcodes,
// branch funct3 codes, PC mux select encodings and the BHT counter reset value.
package branch_predict_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    PC_SEL_FETCH    = 3'b000,
    PC_SEL_JALR     = 3'b001,
    PC_SEL_TARGET   = 3'b010,
    PC_SEL_EXC      = 3'b011,
    PC_SEL_FALLTHRU = 3'b100
  } pc_sel_e;

  // Weakly-not-taken: one step below the taken threshold (MSB set).
  function automatic int weak_nt_val(int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// One BHT entry: saturating up/down counter, resets to weakly-not-taken.
module branch_predict_unit_sat_counter
  import branch_predict_unit_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] ctr
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(weak_nt_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  logic [CTR_BITS-1:0] ctr_d, ctr_q;

  always_comb begin
    ctr_d = ctr_q;
    if (en && inc && (ctr_q != CTR_MAX)) begin
      ctr_d = ctr_q + CTR_ONE;
    end else if (en && dec && (ctr_q != '0)) begin
      ctr_d = ctr_q - CTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= CTR_RST;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage control-flow resolution plus a direct-mapped BHT for fetch prediction.
// Define BRANCH_PERF_EN to build the branch / mispredict performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_pred_taken,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic            ef,
  output logic [2:0]      pc_selection,
  output logic            mispredict,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [CTR_BITS-1:0] bht_ctr [BHT_ENTRIES];
  logic                br_valid, br_taken;
  logic                mispredict_d, mispredict_q;
  pc_sel_e             pc_sel;
  logic                unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Fetch reads the registered table; a same-cycle training write is not bypassed.
  assign if_pred_taken = bht_ctr[if_idx][CTR_BITS-1];

  always_comb begin
    br_valid = 1'b0;
    br_taken = 1'b0;
    if (ex_valid && (ex_opcode == OPC_BRANCH)) begin
      br_valid = 1'b1;
      case (ex_funct3)
        F3_BEQ:  br_taken = zf;
        F3_BNE:  br_taken = !zf;
        F3_BLT:  br_taken = (sf != vf);
        F3_BGE:  br_taken = (sf == vf);
        F3_BLTU: br_taken = !cf;
        F3_BGEU: br_taken = cf;
        default: br_valid = 1'b0;
      endcase
    end
  end

  assign mispredict_d = br_valid && (br_taken != ex_pred_taken);

  always_comb begin
    pc_sel = PC_SEL_FETCH;
    if (ex_valid) begin
      case (ex_opcode)
        OPC_JAL:    pc_sel = PC_SEL_TARGET;
        OPC_JALR:   pc_sel = PC_SEL_JALR;
        OPC_SYSTEM: if (ef) pc_sel = PC_SEL_EXC;
        OPC_BRANCH: if (mispredict_d) pc_sel = br_taken ? PC_SEL_TARGET : PC_SEL_FALLTHRU;
        default:    pc_sel = PC_SEL_FETCH;
      endcase
    end
  end

  assign pc_selection = pc_sel;

  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
    branch_predict_unit_sat_counter #(
      .CTR_BITS(CTR_BITS)
    ) u_ctr (
      .clk (clk),
      .rst (rst),
      .en  (br_valid && (ex_idx == IDX_W'(i))),
      .inc (br_taken),
      .dec (!br_taken),
      .ctr (bht_ctr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= mispredict_d;
    end
  end

  assign mispredict = mispredict_q;

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_br_d, perf_br_q, perf_mp_d, perf_mp_q;

  always_comb begin
    perf_br_d = perf_br_q + {31'b0, br_valid};
    perf_mp_d = perf_mp_q + {31'b0, mispredict_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`else
  assign perf_branches    = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

endmodule
